mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//   Shares one external memory port between the core's instruction and data cache interfaces.
//   Sits between the core (inst_*/data_* ports) and the memory/bus.
//   Serialises requests, one transaction in flight at a time. Returns each response to the
//   requester that issued it. An optional watchdog aborts transactions that stall.
// PARAMETERS
//   DATA_WIDTH       32  address/data width
//   BYTE_DATA_WIDTH  4   byte-enable width (DATA_WIDTH/8)
//   TIMEOUT_CYCLES   256 memory wait limit in BUSY; 0 disables watchdog
//   TIMEOUT_BITS     9   counter width, must hold TIMEOUT_CYCLES
// PORTS
//   clk          in   1     single clock, rising edge
//   rst          in   1     asynchronous, active-low reset
//   inst_req     in   1     instruction fetch request (level, held until inst_valid)
//   inst_addr    in   DW    fetch address
//   inst_valid   out  1     1-cycle response strobe to fetch side
//   inst_data    out  DW    fetch read data, valid with inst_valid
//   data_req     in   1     load/store request (level, held until data_valid)
//   data_we      in   1     1=store, 0=load
//   byte_enable  in   BDW   store byte lanes
//   data_addr    in   DW    load/store address
//   wdata        in   DW    store data
//   data_valid   out  1     1-cycle response strobe to data side
//   rdata        out  DW    load data, valid with data_valid
//   mem_req      out  1     memory request, held until mem_valid
//   mem_we       out  1     memory write enable
//   mem_be       out  BDW   memory byte enables (all ones on fetch)
//   mem_addr     out  DW    memory address
//   mem_wdata    out  DW    memory write data (0 on fetch)
//   mem_valid    in   1     memory completion strobe
//   mem_rdata    in   DW    memory read data, valid with mem_valid
//   err          out  1     1-cycle strobe with *_valid when the watchdog aborted
// BEHAVIOUR
//   - Reset (rst=0, async): all outputs 0, state IDLE, watchdog count 0, last_grant=INST.
//   - FSM: IDLE -> BUSY -> RESP -> IDLE. All outputs registered.
//   - IDLE: sample inst_req/data_req. If any is set, pick a winner, latch its addr/we/be/wdata
//     into the mem_* regs, set mem_req=1, record the winner, go to BUSY.
//   - Fetch grant drives mem_we=0, mem_be=all ones, mem_wdata=0.
//   - BUSY: mem_* held stable, watchdog increments each cycle.
//     On mem_valid=1: mem_req<=0, latch mem_rdata into the winner's data output,
//     set winner's *_valid<=1, go to RESP.
//   - RESP: exactly one cycle with *_valid=1, then *_valid<=0 and go to IDLE.
//     Requests are never sampled in RESP. The requester drops req on seeing valid.
//   - Non-winner data output holds its previous value. Valid strobes are never asserted together.
//   - Latency: req high in cycle 0 -> mem_req in cycle 1.
//     mem_valid in cycle k (k>=1) -> *_valid in cycle k+1.
//     Minimum 3 cycles between grants.
//   - Watchdog (TIMEOUT_CYCLES>0): count reaches TIMEOUT_CYCLES-1 in BUSY without mem_valid ->
//     mem_req<=0, winner *_valid<=1, err<=1, read data<=0, go to RESP.
//     A mem_valid arriving later is ignored while not in BUSY.
//   - Simultaneous mem_valid and timeout in the same cycle: mem_valid wins, err=0.
//   - mem_valid outside BUSY: ignored.
//   - Requests deasserted mid-BUSY: the transaction still completes and responds.
//   - Reset mid-transaction: immediate abort, no response is issued afterwards.
// CONFIGURATION
//   ARB_ROUND_ROBIN_EN undefined:
//     fixed priority, data_req beats inst_req when both are high in IDLE.
//   ARB_ROUND_ROBIN_EN defined:
//     when both are high, grant the side not in last_grant.
//     last_grant updates on every grant and resets to INST, so the first tie goes to data.
//   Single requester: granted directly in both modes.
// TESTING
//   1. Fetch: inst_req=1, inst_addr=0x100, mem_valid 2 cycles after mem_req with rdata=0xDEADBEEF
//      -> mem_addr=0x100, mem_be=0xF, mem_we=0; inst_valid=1 for 1 cycle with inst_data=0xDEADBEEF.
//   2. Store: data_req=1, data_we=1, byte_enable=0x3, data_addr=0x40, wdata=0x1234, mem_valid next cycle
//      -> mem_we=1, mem_be=0x3, mem_wdata=0x1234; data_valid one cycle; inst_valid stays 0.
//   3. Tie, both req held, 3 transactions:
//      fixed -> grant order D,D,D (data_req held); with ARB_ROUND_ROBIN_EN -> D,I,D.
//   4. Timeout, TIMEOUT_CYCLES=4: mem_valid never asserted -> after 4 BUSY cycles
//      inst_valid=1, err=1, inst_data=0. Late mem_valid 2 cycles afterwards -> no second strobe.
//   5. Reset mid-BUSY: rst low for 1 cycle, asynchronously
//      -> mem_req=0 immediately, no *_valid afterwards. Next inst_req served normally.
//   6. mem_valid while IDLE, and mem_valid coincident with the timeout cycle
//      -> no strobe in the first case; normal response with err=0 in the second.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between instruction fetch and load/store requesters.
// Define ARB_ROUND_ROBIN_EN for round-robin tie-breaking; default gives data priority over fetch.
module mem_port_arbiter #(
    parameter int DATA_WIDTH      = 32,
    parameter int BYTE_DATA_WIDTH = 4,
    parameter int TIMEOUT_CYCLES  = 256,
    parameter int TIMEOUT_BITS    = 9
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       inst_req,
    input  logic [DATA_WIDTH-1:0]      inst_addr,
    output logic                       inst_valid,
    output logic [DATA_WIDTH-1:0]      inst_data,
    input  logic                       data_req,
    input  logic                       data_we,
    input  logic [BYTE_DATA_WIDTH-1:0] byte_enable,
    input  logic [DATA_WIDTH-1:0]      data_addr,
    input  logic [DATA_WIDTH-1:0]      wdata,
    output logic                       data_valid,
    output logic [DATA_WIDTH-1:0]      rdata,
    output logic                       mem_req,
    output logic                       mem_we,
    output logic [BYTE_DATA_WIDTH-1:0] mem_be,
    output logic [DATA_WIDTH-1:0]      mem_addr,
    output logic [DATA_WIDTH-1:0]      mem_wdata,
    input  logic                       mem_valid,
    input  logic [DATA_WIDTH-1:0]      mem_rdata,
    output logic                       err
);

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
    typedef enum logic {GRANT_INST, GRANT_DATA} grant_t;

    localparam logic [TIMEOUT_BITS-1:0] WD_LAST =
        TIMEOUT_BITS'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    state_t                  state, state_next;
    grant_t                  winner;
    logic [TIMEOUT_BITS-1:0] wd_cnt;
    logic                    any_req;
    logic                    pick_data;
    logic                    timeout_hit;

    assign any_req     = inst_req | data_req;
    assign timeout_hit = (TIMEOUT_CYCLES > 0) && (wd_cnt == WD_LAST);

`ifdef ARB_ROUND_ROBIN_EN
    grant_t last_grant;

    // On a tie, serve whichever side was not granted last; reset favours data first.
    assign pick_data = data_req & (~inst_req | (last_grant == GRANT_INST));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            last_grant <= GRANT_INST;
        else if (state == IDLE && any_req)
            last_grant <= pick_data ? GRANT_DATA : GRANT_INST;
    end
`else
    assign pick_data = data_req;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state <= IDLE;
        else
            state <= state_next;
    end

    // NOTE: state_next is defaulted before the case so no path leaves it unassigned (no latch).
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (any_req) state_next = BUSY;
            BUSY:    if (mem_valid || timeout_hit) state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // NOTE: every register here uses <= so all of them see the same pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            winner     <= GRANT_INST;
            wd_cnt     <= '0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_be     <= '0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            inst_valid <= 1'b0;
            inst_data  <= '0;
            data_valid <= 1'b0;
            rdata      <= '0;
            err        <= 1'b0;
        end else begin
            inst_valid <= 1'b0;
            data_valid <= 1'b0;
            err        <= 1'b0;
            case (state)
                IDLE: begin
                    if (any_req) begin
                        mem_req <= 1'b1;
                        wd_cnt  <= '0;
                        if (pick_data) begin
                            winner    <= GRANT_DATA;
                            mem_we    <= data_we;
                            mem_be    <= byte_enable;
                            mem_addr  <= data_addr;
                            mem_wdata <= wdata;
                        end else begin
                            winner    <= GRANT_INST;
                            mem_we    <= 1'b0;
                            mem_be    <= '1;
                            mem_addr  <= inst_addr;
                            mem_wdata <= '0;
                        end
                    end
                end
                BUSY: begin
                    // A real completion takes precedence over a watchdog expiry in the same cycle.
                    if (mem_valid) begin
                        mem_req <= 1'b0;
                        if (winner == GRANT_DATA) begin
                            rdata      <= mem_rdata;
                            data_valid <= 1'b1;
                        end else begin
                            inst_data  <= mem_rdata;
                            inst_valid <= 1'b1;
                        end
                    end else if (timeout_hit) begin
                        mem_req <= 1'b0;
                        err     <= 1'b1;
                        if (winner == GRANT_DATA) begin
                            rdata      <= '0;
                            data_valid <= 1'b1;
                        end else begin
                            inst_data  <= '0;
                            inst_valid <= 1'b1;
                        end
                    end else begin
                        wd_cnt <= wd_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed checks of mem_port_arbiter with a 4-cycle watchdog.
// Expected tie-break order follows ARB_ROUND_ROBIN_EN.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_valid;
    logic [31:0] inst_data;
    logic        data_req;
    logic        data_we;
    logic [3:0]  byte_enable;
    logic [31:0] data_addr;
    logic [31:0] wdata;
    logic        data_valid;
    logic [31:0] rdata;
    logic        mem_req;
    logic        mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_valid;
    logic [31:0] mem_rdata;
    logic        err;

    int checks   = 0;
    int failures = 0;

    mem_port_arbiter #(
        .DATA_WIDTH      (32),
        .BYTE_DATA_WIDTH (4),
        .TIMEOUT_CYCLES  (4),
        .TIMEOUT_BITS    (9)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .inst_req    (inst_req),
        .inst_addr   (inst_addr),
        .inst_valid  (inst_valid),
        .inst_data   (inst_data),
        .data_req    (data_req),
        .data_we     (data_we),
        .byte_enable (byte_enable),
        .data_addr   (data_addr),
        .wdata       (wdata),
        .data_valid  (data_valid),
        .rdata       (rdata),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .mem_be      (mem_be),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_valid   (mem_valid),
        .mem_rdata   (mem_rdata),
        .err         (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic check1(input string tag, input logic got, input logic exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s: observed=%b expected=%b", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    logic exp_data [3];

    initial begin
`ifdef ARB_ROUND_ROBIN_EN
        exp_data[0] = 1'b1; exp_data[1] = 1'b0; exp_data[2] = 1'b1;
`else
        exp_data[0] = 1'b1; exp_data[1] = 1'b1; exp_data[2] = 1'b1;
`endif
        rst = 1'b0;
        inst_req = 1'b0; inst_addr = '0;
        data_req = 1'b0; data_we = 1'b0; byte_enable = '0; data_addr = '0; wdata = '0;
        mem_valid = 1'b0; mem_rdata = '0;
        tick(); tick();

        // Reset state
        check1("rst_mem_req", mem_req, 1'b0);
        check1("rst_inst_valid", inst_valid, 1'b0);
        check1("rst_data_valid", data_valid, 1'b0);
        check1("rst_err", err, 1'b0);
        check("rst_mem_addr", mem_addr, 32'h0);
        check("rst_inst_data", inst_data, 32'h0);
        rst = 1'b1;
        tick();

        // 1. Fetch, memory answers two cycles after mem_req
        inst_req = 1'b1; inst_addr = 32'h100;
        tick();
        check1("f_mem_req", mem_req, 1'b1);
        check("f_mem_addr", mem_addr, 32'h100);
        check("f_mem_be", 32'(mem_be), 32'hF);
        check1("f_mem_we", mem_we, 1'b0);
        check("f_mem_wdata", mem_wdata, 32'h0);
        tick();
        check1("f_wait_valid", inst_valid, 1'b0);
        check1("f_wait_req", mem_req, 1'b1);
        tick();
        mem_valid = 1'b1; mem_rdata = 32'hDEADBEEF;
        tick();
        check1("f_inst_valid", inst_valid, 1'b1);
        check("f_inst_data", inst_data, 32'hDEADBEEF);
        check1("f_err", err, 1'b0);
        check1("f_data_valid", data_valid, 1'b0);
        check1("f_mem_req_drop", mem_req, 1'b0);
        mem_valid = 1'b0; inst_req = 1'b0;
        tick();
        check1("f_valid_one_cycle", inst_valid, 1'b0);

        // 2. Store, memory answers next cycle
        data_req = 1'b1; data_we = 1'b1; byte_enable = 4'h3; data_addr = 32'h40; wdata = 32'h1234;
        tick();
        check1("s_mem_we", mem_we, 1'b1);
        check("s_mem_be", 32'(mem_be), 32'h3);
        check("s_mem_wdata", mem_wdata, 32'h1234);
        check("s_mem_addr", mem_addr, 32'h40);
        mem_valid = 1'b1; mem_rdata = 32'h5555AAAA;
        tick();
        check1("s_data_valid", data_valid, 1'b1);
        check1("s_inst_valid", inst_valid, 1'b0);
        check("s_inst_data_hold", inst_data, 32'hDEADBEEF);
        mem_valid = 1'b0; data_req = 1'b0; data_we = 1'b0;
        tick();
        check1("s_valid_one_cycle", data_valid, 1'b0);

        // 3. Tie with both requests held, from a fresh reset
        rst = 1'b0;
        tick();
        rst = 1'b1;
        inst_req = 1'b1; inst_addr = 32'h200;
        data_req = 1'b1; data_addr = 32'h300; byte_enable = 4'hF;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("tie_mem_addr", mem_addr, exp_data[i] ? 32'h300 : 32'h200);
            mem_valid = 1'b1; mem_rdata = 32'hA0000000 + 32'(i);
            tick();
            check1("tie_data_valid", data_valid, exp_data[i]);
            check1("tie_inst_valid", inst_valid, ~exp_data[i]);
            mem_valid = 1'b0;
            tick();
        end
        inst_req = 1'b0; data_req = 1'b0;
        tick();

        // 4. Watchdog abort, then a late mem_valid while idle
        inst_req = 1'b1; inst_addr = 32'h500;
        tick();
        check1("to_mem_req", mem_req, 1'b1);
        tick(); tick(); tick();
        check1("to_busy4_req", mem_req, 1'b1);
        check1("to_busy4_valid", inst_valid, 1'b0);
        tick();
        check1("to_inst_valid", inst_valid, 1'b1);
        check1("to_err", err, 1'b1);
        check("to_inst_data", inst_data, 32'h0);
        check1("to_mem_req_drop", mem_req, 1'b0);
        inst_req = 1'b0;
        tick();
        check1("to_err_one_cycle", err, 1'b0);
        tick();
        mem_valid = 1'b1; mem_rdata = 32'h12345678;
        tick();
        check1("late_inst_valid", inst_valid, 1'b0);
        check1("late_data_valid", data_valid, 1'b0);
        check1("late_mem_req", mem_req, 1'b0);
        mem_valid = 1'b0;

        // 6b. mem_valid on the same cycle the watchdog would expire
        inst_req = 1'b1; inst_addr = 32'h600;
        tick(); tick(); tick(); tick();
        mem_valid = 1'b1; mem_rdata = 32'hCAFEF00D;
        tick();
        check1("co_inst_valid", inst_valid, 1'b1);
        check1("co_err", err, 1'b0);
        check("co_inst_data", inst_data, 32'hCAFEF00D);
        mem_valid = 1'b0; inst_req = 1'b0;
        tick();

        // 5. Asynchronous reset in the middle of BUSY
        inst_req = 1'b1; inst_addr = 32'h700;
        tick();
        check1("rb_mem_req", mem_req, 1'b1);
        #2 rst = 1'b0;
        #1 check1("rb_async_mem_req", mem_req, 1'b0);
        inst_req = 1'b0;
        tick();
        rst = 1'b1;
        mem_valid = 1'b1; mem_rdata = 32'h77777777;
        tick();
        check1("rb_no_inst_valid", inst_valid, 1'b0);
        check1("rb_no_data_valid", data_valid, 1'b0);
        mem_valid = 1'b0;
        tick();
        check1("rb_still_no_valid", inst_valid, 1'b0);
        inst_req = 1'b1; inst_addr = 32'h800;
        tick();
        check("rb_next_addr", mem_addr, 32'h800);
        mem_valid = 1'b1; mem_rdata = 32'h0BADF00D;
        tick();
        check1("rb_next_valid", inst_valid, 1'b1);
        check("rb_next_data", inst_data, 32'h0BADF00D);
        mem_valid = 1'b0; inst_req = 1'b0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
